// File: rtl/ccu25_pkg.sv
// Shared CCU25 event-format definitions: writer FSM states, marker defaults
// and header/trailer field positions (also used by the link-side decoder).
package ccu25_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      PAYLOAD,
      FLUSH,
      TRAILER,
      WAIT_TX
   } state_e;

   localparam logic [7:0] HDR_MARK_DEF = 8'hA5;
   localparam logic [7:0] TRL_MARK_DEF = 8'h5A;

   // Field positions inside the 64-bit header/trailer words
   localparam int MARK_LSB      = 56;
   localparam int HDR_RUN_LSB   = 32;
   localparam int HDR_ORBIT_LSB = 0;
   localparam int TRL_TRUNC_BIT = 48;
   localparam int TRL_COUNT_LSB = 32;
   localparam int TRL_CKSUM_LSB = 0;

   function automatic logic [63:0] pack_header(input logic [7:0]  mark,
                                               input logic [23:0] run,
                                               input logic [31:0] orbit);
      logic [63:0] w;
      w = '0;
      w[MARK_LSB +: 8]       = mark;
      w[HDR_RUN_LSB +: 24]   = run;
      w[HDR_ORBIT_LSB +: 32] = orbit;
      return w;
   endfunction

   function automatic logic [63:0] pack_trailer(input logic [7:0]  mark,
                                                input logic        truncated,
                                                input logic [15:0] count,
                                                input logic [31:0] cksum);
      logic [63:0] w;
      w = '0;
      w[MARK_LSB +: 8]       = mark;
      w[TRL_TRUNC_BIT]       = truncated;
      w[TRL_COUNT_LSB +: 16] = count;
      w[TRL_CKSUM_LSB +: 32] = cksum;
      return w;
   endfunction

endpackage

// File: rtl/ccu25_event_writer_if.sv
// Hit stream and FIFO write bus of the event writer.
// master = the writer (accepts hits, drives the FIFO), slave = its environment.
interface ccu25_event_writer_if;
   logic        hit_valid;
   logic [31:0] hit_data;
   logic        hit_last;
   logic        hit_ready;
   logic        fifo_full;
   logic        fifo_we;
   logic [63:0] fifo_wdata;

   modport master (
      input  hit_valid, hit_data, hit_last, fifo_full,
      output hit_ready, fifo_we, fifo_wdata
   );

   modport slave (
      output hit_valid, hit_data, hit_last, fifo_full,
      input  hit_ready, fifo_we, fifo_wdata
   );
endinterface

// File: rtl/ccu25_event_writer.sv
// CCU25 event writer: on a trigger writes header, packed hit pairs and a
// trailer into the event FIFO, then requests transmission and waits for it.
module ccu25_event_writer
   import ccu25_pkg::*;
#(
   parameter int unsigned MAX_HITS = 1024,
   parameter logic [7:0]  HDR_MARK = HDR_MARK_DEF,
   parameter logic [7:0]  TRL_MARK = TRL_MARK_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        trigger,
   input  logic [31:0]                 orbit_number,
   input  logic [23:0]                 run_number,
   ccu25_event_writer_if.master        bus,
   input  logic                        transmit_complete,
   output logic                        transmit_request,
   output logic                        busy,
   output logic [15:0]                 drop_count
);

   state_e      state_q, state_d;
   logic [31:0] orbit_q, orbit_d;
   logic [23:0] run_q, run_d;
   logic [31:0] half_q, half_d;
   logic        half_valid_q, half_valid_d;
   logic [15:0] hit_count_q, hit_count_d;
   logic [31:0] checksum_q, checksum_d;
   logic        trunc_q, trunc_d;
   logic        fifo_we_q, fifo_we_d;
   logic [63:0] fifo_wdata_q, fifo_wdata_d;
   logic [15:0] drop_count_q, drop_count_d;

   logic        hit_ready_c;
   logic        hit_take;
   logic        pend;

   // A held half word can only be completed when the FIFO can take the pair
   assign hit_ready_c = (state_q == PAYLOAD) && (!half_valid_q || !bus.fifo_full);
   assign hit_take    = hit_ready_c && bus.hit_valid;

   // Next-state, packing and bookkeeping for the whole event sequence
   always_comb begin
      state_d      = state_q;
      orbit_d      = orbit_q;
      run_d        = run_q;
      half_d       = half_q;
      half_valid_d = half_valid_q;
      hit_count_d  = hit_count_q;
      checksum_d   = checksum_q;
      trunc_d      = trunc_q;
      fifo_we_d    = 1'b0;
      fifo_wdata_d = fifo_wdata_q;
      drop_count_d = drop_count_q;
      pend         = half_valid_q;

      if (trigger && (state_q != IDLE) && (drop_count_q != 16'hFFFF))
         drop_count_d = drop_count_q + 16'd1;

      case (state_q)
         IDLE: begin
            if (trigger) begin
               orbit_d = orbit_number;
               run_d   = run_number;
               state_d = HEADER;
            end
         end
         HEADER: begin
            if (!bus.fifo_full) begin
               fifo_we_d    = 1'b1;
               fifo_wdata_d = pack_header(HDR_MARK, run_q, orbit_q);
               state_d      = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (hit_take) begin
               if (32'(hit_count_q) < MAX_HITS) begin
                  if (hit_count_q != 16'hFFFF)
                     hit_count_d = hit_count_q + 16'd1;
                  if (half_valid_q) begin
                     fifo_we_d    = 1'b1;
                     fifo_wdata_d = {half_q, bus.hit_data};
                     checksum_d   = checksum_q ^ half_q ^ bus.hit_data;
                     half_valid_d = 1'b0;
                     pend         = 1'b0;
                  end else begin
                     half_d       = bus.hit_data;
                     half_valid_d = 1'b1;
                     pend         = 1'b1;
                  end
               end else begin
                  trunc_d = 1'b1;
               end
               if (bus.hit_last)
                  state_d = pend ? FLUSH : TRAILER;
            end
         end
         FLUSH: begin
            if (!bus.fifo_full) begin
               fifo_we_d    = 1'b1;
               fifo_wdata_d = {half_q, 32'h0};
               checksum_d   = checksum_q ^ half_q;
               half_valid_d = 1'b0;
               state_d      = TRAILER;
            end
         end
         TRAILER: begin
            if (!bus.fifo_full) begin
               fifo_we_d    = 1'b1;
               fifo_wdata_d = pack_trailer(TRL_MARK, trunc_q, hit_count_q, checksum_q);
               state_d      = WAIT_TX;
            end
         end
         WAIT_TX: begin
            if (transmit_complete) begin
               state_d      = IDLE;
               hit_count_d  = '0;
               checksum_d   = '0;
               trunc_d      = 1'b0;
               half_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any event in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         orbit_q      <= '0;
         run_q        <= '0;
         half_q       <= '0;
         half_valid_q <= 1'b0;
         hit_count_q  <= '0;
         checksum_q   <= '0;
         trunc_q      <= 1'b0;
         fifo_we_q    <= 1'b0;
         fifo_wdata_q <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         orbit_q      <= orbit_d;
         run_q        <= run_d;
         half_q       <= half_d;
         half_valid_q <= half_valid_d;
         hit_count_q  <= hit_count_d;
         checksum_q   <= checksum_d;
         trunc_q      <= trunc_d;
         fifo_we_q    <= fifo_we_d;
         fifo_wdata_q <= fifo_wdata_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign bus.hit_ready     = hit_ready_c;
   assign bus.fifo_we       = fifo_we_q;
   assign bus.fifo_wdata    = fifo_wdata_q;
   assign transmit_request  = (state_q == WAIT_TX);
   assign busy              = (state_q != IDLE);
   assign drop_count        = drop_count_q;

endmodule

// File: tb/tb_ccu25_event_writer.sv
// Self-checking bench for ccu25_event_writer: directed table, multi-cycle
// corner sequences and randomized events against a word-list reference model.
module tb_ccu25_event_writer;
   import ccu25_pkg::*;

   localparam int TB_MAX = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        trigger = 1'b0;
   logic [31:0] orbit_number = '0;
   logic [23:0] run_number = '0;
   logic        transmit_complete = 1'b0;
   logic        transmit_request;
   logic        busy;
   logic [15:0] drop_count;

   ccu25_event_writer_if ifc();

   ccu25_event_writer #(.MAX_HITS(TB_MAX)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .trigger           (trigger),
      .orbit_number      (orbit_number),
      .run_number        (run_number),
      .bus               (ifc),
      .transmit_complete (transmit_complete),
      .transmit_request  (transmit_request),
      .busy              (busy),
      .drop_count        (drop_count)
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail = 0;
   int          exp_drop = 0;
   bit          done = 1'b0;
   logic        full_prev = 1'b0;
   logic [63:0] wq[$];
   logic [63:0] exp_q[$];
   logic [31:0] hits_q[$];

   typedef struct packed {
      logic [31:0]      orbit;
      logic [23:0]      run;
      logic [3:0]       n;
      logic [5:0][31:0] hits;
      logic [63:0]      exp_trl;
   } vec_t;

   vec_t tbl[5];

   function automatic vec_t mkv(input logic [31:0] o, input logic [23:0] r, input int n,
                                input logic [31:0] h0, input logic [31:0] h1, input logic [31:0] h2,
                                input logic [31:0] h3, input logic [31:0] h4, input logic [31:0] h5,
                                input logic [63:0] t);
      vec_t v;
      v.orbit   = o;
      v.run     = r;
      v.n       = 4'(n);
      v.hits[0] = h0; v.hits[1] = h1; v.hits[2] = h2;
      v.hits[3] = h3; v.hits[4] = h4; v.hits[5] = h5;
      v.exp_trl = t;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // FIFO-side monitor: collects written words; a strobe must follow a not-full cycle
   always @(posedge clk) begin
      if (ifc.fifo_we === 1'b1) begin
         wq.push_back(ifc.fifo_wdata);
         n_assert++;
         if (full_prev) begin
            n_fail++;
            $display("FAIL full_rule: got fifo_we=1 after fifo_full=1, expected no write");
         end
      end
      full_prev = ifc.fifo_full;
   end

   // Reference model: header, stored hits paired (zero pad), trailer with count/flag/xor
   task automatic build_expected(input logic [31:0] orb, input logic [23:0] rn);
      int          stored;
      logic [31:0] a, b, cks;
      logic        tr;
      exp_q.delete();
      exp_q.push_back({8'hA5, rn, orb});
      stored = (hits_q.size() > TB_MAX) ? TB_MAX : hits_q.size();
      tr     = (hits_q.size() > TB_MAX) ? 1'b1 : 1'b0;
      cks    = '0;
      for (int i = 0; i < stored; i += 2) begin
         a = hits_q[i];
         b = (i + 1 < stored) ? hits_q[i+1] : 32'h0;
         exp_q.push_back({a, b});
         cks = cks ^ a ^ b;
      end
      exp_q.push_back({8'h5A, 7'h0, tr, 16'(stored), cks});
   endtask

   task automatic pulse_trigger(input logic [31:0] orb, input logic [23:0] rn);
      orbit_number = orb;
      run_number   = rn;
      trigger      = 1'b1;
      @(posedge clk); #1;
      trigger      = 1'b0;
      orbit_number = $urandom;
      run_number   = 24'($urandom);
   endtask

   task automatic send_hit(input logic [31:0] d, input logic last, input bit gaps);
      bit ok;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      ifc.hit_valid = 1'b1;
      ifc.hit_data  = d;
      ifc.hit_last  = last;
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         ok = ifc.hit_ready;
         @(posedge clk); #1;
      end
      ifc.hit_valid = 1'b0;
      ifc.hit_last  = 1'b0;
      if (!ok) chk("hit_accept_timeout", 64'(ok), 64'd1);
   endtask

   task automatic run_event(input logic [31:0] orb, input logic [23:0] rn,
                            input bit gaps, input bit rand_full);
      wq.delete();
      build_expected(orb, rn);
      pulse_trigger(orb, rn);
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < hits_q.size(); i++)
               send_hit(hits_q[i], (i == hits_q.size() - 1), gaps);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               ifc.fifo_full = rand_full && ($urandom_range(0, 2) == 0);
            end
            ifc.fifo_full = 1'b0;
         end
      join
   endtask

   // Waits for transmit_request then compares the written words with the model
   task automatic wait_tx(input string name);
      bit ok;
      int nw;
      ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         ok = transmit_request;
      end
      chk({name, " tx_req"}, 64'(ok), 64'd1);
      @(posedge clk); #1;
      chk({name, " nwords"}, 64'(wq.size()), 64'(exp_q.size()));
      nw = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
      for (int i = 0; i < nw; i++)
         chk($sformatf("%s word%0d", name, i), wq[i], exp_q[i]);
      $display("event %s: %0d hits, %0d words written, %0d expected",
               name, hits_q.size(), wq.size(), exp_q.size());
   endtask

   task automatic complete_tx(input bit with_trig);
      repeat ($urandom_range(1, 3)) begin
         @(negedge clk);
         chk("hold tx_req", 64'(transmit_request), 64'd1);
         chk("hit_ready in wait_tx", 64'(ifc.hit_ready), 64'd0);
      end
      @(posedge clk); #1;
      transmit_complete = 1'b1;
      trigger           = with_trig;
      @(posedge clk); #1;
      transmit_complete = 1'b0;
      trigger           = 1'b0;
      if (with_trig) exp_drop++;
      @(negedge clk);
      chk("busy after complete", 64'(busy), 64'd0);
      chk("tx_req after complete", 64'(transmit_request), 64'd0);
      chk("drop_count", 64'(drop_count), 64'(exp_drop));
   endtask

   task automatic check_all_zero(input string name);
      chk({name, " fifo_we"},    64'(ifc.fifo_we), 64'd0);
      chk({name, " fifo_wdata"}, ifc.fifo_wdata, 64'd0);
      chk({name, " hit_ready"},  64'(ifc.hit_ready), 64'd0);
      chk({name, " tx_req"},     64'(transmit_request), 64'd0);
      chk({name, " busy"},       64'(busy), 64'd0);
      chk({name, " drop_count"}, 64'(drop_count), 64'd0);
   endtask

   task automatic load_vec(input int i);
      hits_q.delete();
      for (int j = 0; j < int'(tbl[i].n); j++) hits_q.push_back(tbl[i].hits[j]);
   endtask

   // Global time limit
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected test completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] last_w;

      tbl[0] = mkv(32'h10, 24'h000123, 3, 32'h11111111, 32'h22222222, 32'h33333333, 0, 0, 0,
                   64'h5A000003_00000000);
      tbl[1] = mkv(32'h20, 24'h000456, 6, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6,
                   64'h5A010004_00000004);
      tbl[2] = mkv(32'h30, 24'h000789, 2, 32'hAAAA0000, 32'h0000BBBB, 0, 0, 0, 0,
                   64'h5A000002_AAAABBBB);
      tbl[3] = mkv(32'h40, 24'hABCDEF, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0,
                   64'h5A000001_DEADBEEF);
      tbl[4] = mkv(32'h50, 24'h000001, 5, 32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 0,
                   64'h5A010004_00000040);

      ifc.hit_valid = 1'b0;
      ifc.hit_data  = '0;
      ifc.hit_last  = 1'b0;
      ifc.fifo_full = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 5; i++) begin
         load_vec(i);
         run_event(tbl[i].orbit, tbl[i].run, 1'b0, 1'b0);
         wait_tx($sformatf("table%0d", i));
         last_w = (wq.size() > 0) ? wq[wq.size()-1] : 64'hx;
         chk($sformatf("table%0d trailer", i), last_w, tbl[i].exp_trl);
         complete_tx(1'b0);
      end

      // FIFO stall: 5 cycles during header, 3 cycles with a half word held
      load_vec(0);
      wq.delete();
      build_expected(tbl[0].orbit, tbl[0].run);
      ifc.fifo_full = 1'b1;
      pulse_trigger(tbl[0].orbit, tbl[0].run);
      repeat (5) begin
         @(negedge clk);
         chk("stall hdr fifo_we", 64'(ifc.fifo_we), 64'd0);
         chk("stall hdr busy", 64'(busy), 64'd1);
         @(posedge clk); #1;
      end
      ifc.fifo_full = 1'b0;
      send_hit(hits_q[0], 1'b0, 1'b0);
      ifc.fifo_full = 1'b1;
      ifc.hit_valid = 1'b1;
      ifc.hit_data  = hits_q[1];
      repeat (3) begin
         @(negedge clk);
         chk("stall pay hit_ready", 64'(ifc.hit_ready), 64'd0);
         chk("stall pay fifo_we", 64'(ifc.fifo_we), 64'd0);
         @(posedge clk); #1;
      end
      ifc.fifo_full = 1'b0;
      send_hit(hits_q[1], 1'b0, 1'b0);
      send_hit(hits_q[2], 1'b1, 1'b0);
      wait_tx("stall");
      complete_tx(1'b0);

      // Reset in the middle of a payload
      hits_q = '{32'hCAFE0001, 32'hCAFE0002};
      pulse_trigger(32'h77, 24'h77);
      send_hit(hits_q[0], 1'b0, 1'b0);
      send_hit(hits_q[1], 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      exp_drop = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      load_vec(2);
      run_event(tbl[2].orbit, tbl[2].run, 1'b0, 1'b0);
      wait_tx("after_reset");
      complete_tx(1'b0);

      // Triggers while busy are dropped; the running event is unaffected
      load_vec(0);
      wq.delete();
      build_expected(32'h1234, 24'h5678);
      pulse_trigger(32'h1234, 24'h5678);
      send_hit(hits_q[0], 1'b0, 1'b0);
      pulse_trigger(32'hBAD, 24'hBAD);
      exp_drop++;
      send_hit(hits_q[1], 1'b0, 1'b0);
      send_hit(hits_q[2], 1'b1, 1'b0);
      wait_tx("drop");
      pulse_trigger(32'hBAD2, 24'hBAD2);
      exp_drop++;
      @(negedge clk);
      chk("drop_count two", 64'(drop_count), 64'd2);
      complete_tx(1'b1);
      load_vec(3);
      run_event(tbl[3].orbit, tbl[3].run, 1'b0, 1'b0);
      wait_tx("post_drop");
      complete_tx(1'b0);

      // Randomized events with hit gaps and FIFO back-pressure
      for (int e = 0; e < 25; e++) begin
         int n;
         n = $urandom_range(1, 7);
         hits_q.delete();
         for (int j = 0; j < n; j++) hits_q.push_back($urandom);
         run_event($urandom, 24'($urandom), 1'b1, 1'b1);
         wait_tx($sformatf("rand%0d", e));
         complete_tx(1'b0);
      end

      @(negedge clk);
      chk("final drop_count", 64'(drop_count), 64'(exp_drop));
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
